ysyx_22050612_lsu: RTL and testbench
====================================

# ysyx_22050612_lsu

Parametrised, multi-cycle load/store unit sitting between the execute stage and the data-memory port. It replaces the fixed-width, combinational DPI memory access of the single-cycle core with valid/ready handshakes on both sides. It supports byte/half/word/double accesses with correct lane masks, sign/zero extension and misalignment detection.

## Interface
- XLEN, default 64: data width in bits; 32 or 64 only.
- ADDR_W, default 64: address width.
- clk in 1: clock; all state changes on rising edge.
- rst in 1: synchronous, active-high reset.
- in_valid in 1: request from execute stage.
- in_ready out 1: LSU can accept; high only in IDLE.
- in_store in 1: 1 = store, 0 = load.
- in_size in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- in_unsigned in 1: load zero-extends when 1; ignored for stores.
- in_addr in ADDR_W: byte address, already computed by the ALU.
- in_wdata in XLEN: store data, right-aligned.
- in_rd in 5: destination register tag, returned unchanged.
- mem_req_valid out 1: memory request.
- mem_req_ready in 1: memory accepts the request.
- mem_we out 1: write enable.
- mem_addr out ADDR_W: in_addr with the low log2(XLEN/8) bits cleared.
- mem_wdata out XLEN: store data shifted to its byte lane.
- mem_wmask out XLEN/8: byte-enable mask; all zeros for loads.
- mem_rsp_valid in 1: read data / write acknowledge.
- mem_rdata in XLEN: full aligned word.
- out_valid out 1: result available.
- out_ready in 1: writeback accepts.
- out_rdata out XLEN: extended load data; 0 for stores and errors.
- out_rd out 5: tag of the completed access.
- out_wen out 1: high when out_rdata must be written to in_rd (load, no error, rd≠0).
- out_err out 1: misaligned or illegal-size access.

## Operation
- FSM states are IDLE, REQ, WAIT and RESP. Reset value is IDLE.
- All request fields are latched on the in_valid & in_ready handshake.
- Address offset: off = addr[log2(XLEN/8)-1:0].
- Byte count: n = 1 << size.
- Error condition: (addr & (n-1)) ≠ 0, or size = 3 with XLEN = 32.
- IDLE → REQ on accept with no error.
- IDLE → RESP on accept with error. No memory request is issued; out_err = 1 and out_wen = 0.
- REQ: mem_req_valid = 1 with stable fields.
  - Stores: mem_wmask = ((1<<n)-1) << off and mem_wdata = in_wdata << (8·off).
  - Loads: mem_wmask = 0.
  - REQ → WAIT on mem_req_ready.
- WAIT: when mem_rsp_valid is seen, latch mem_rdata and go to RESP.
  - Load result: field = (mem_rdata >> 8·off)[8n-1:0], sign-extended, or zero-extended if in_unsigned, to XLEN.
  - Store result: out_rdata = 0.
- RESP: out_valid = 1 with out_* fields stable. RESP → IDLE on out_ready.
- mem_rsp_valid is ignored in every state except WAIT.
- Requests are never reordered; exactly one access is outstanding at a time.

## Timing
- Reset values: in_ready = 1; mem_req_valid, mem_we, out_valid, out_wen, out_err = 0; mem_wmask, mem_wdata, mem_addr, out_rdata, out_rd = 0.
- Best-case latency with ready signals high and the response one cycle after the request handshake:
  - accept at edge T;
  - mem_req_valid high in cycle T+1;
  - mem_rsp_valid in cycle T+2;
  - out_valid in cycle T+3.
- Error path: out_valid in cycle T+1.
- All outputs are registered; no combinational path from in_* to mem_* or out_*.
- mem_req_valid, once raised, stays high with unchanged fields until mem_req_ready.
- out_valid, once raised, stays high with unchanged fields until out_ready.
- in_ready is low from the accept edge until the cycle after the out_valid & out_ready handshake. No back-to-back accept in the same cycle as output completion.
- Memory guarantees mem_rsp_valid ≥ 1 cycle after the request handshake.
- rst in any state forces IDLE next edge and applies all reset values. A memory response arriving afterwards is dropped.

## Test plan
- Store half, XLEN=64: addr 0x8000_0006, wdata 0x1234 → mem_addr 0x8000_0000, mem_wmask 0xC0, mem_wdata 0x1234_0000_0000_0000, mem_we 1; then out_valid, out_wen 0, out_err 0.
- Load byte: addr 0x8000_0003, mem_rdata 0x0000_0000_8000_0000 → signed out_rdata 0xFFFF_FFFF_FFFF_FF80; unsigned 0x80; out_rd echoes in_rd = 5 with out_wen 1.
- Load word: addr 0x8000_0004, mem_rdata 0x8765_4321_0000_0000 → signed 0xFFFF_FFFF_8765_4321; unsigned 0x0000_0000_8765_4321. Zero-wait case shows out_valid exactly 3 cycles after accept.
- Misaligned word at 0x8000_0002 → mem_req_valid never rises; out_valid 1 cycle after accept with out_err 1, out_wen 0, out_rdata 0. The XLEN=32 build with size 3 gives the same result.
- Backpressure: hold mem_req_ready low 3 cycles, delay mem_rsp_valid 4 cycles, hold out_ready low 2 cycles → mem_* and out_* stay stable while waiting, in_ready stays 0, exactly one memory request, exactly one result.
- Reset in WAIT: assert rst for 1 cycle, then send mem_rsp_valid → FSM in IDLE, all outputs at reset values, stale response ignored. A fresh load completes normally.

Source files
------------

// File: rtl/ysyx_22050612_lsu_if.sv
// Handshake bundle between execute stage, LSU and data memory.
// slave = LSU side, master = the environment driving it.
interface ysyx_22050612_lsu_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic              in_store;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [4:0]        in_rd;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rdata;
  logic [4:0]        out_rd;
  logic              out_wen;
  logic              out_err;

  modport slave (
    input  in_valid, in_store, in_size,
    input  in_unsigned, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req_valid, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output out_valid, out_rdata, out_rd,
    output out_wen, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_store, in_size,
    output in_unsigned, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  out_valid, out_rdata, out_rd,
    input  out_wen, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one outstanding access,
// lane masking, load extension and misalignment trapping.
module ysyx_22050612_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_22050612_lsu_if.slave    bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_t;

  state_t state, state_nx;

  logic          st_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [OW-1:0] off_q;

  logic          accept;
  logic [OW-1:0] off_in;
  logic [2:0]    amask;
  logic [NB-1:0] lmask;
  logic          err_in;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld_ext;

  assign accept = bus.in_valid && (state == IDLE);
  assign off_in = bus.in_addr[OW-1:0];

  always_comb begin
    amask = 3'd0;
    lmask = '1;
    unique case (1'b1)
      bus.in_size == 2'd0: begin
        amask = 3'd0;
        lmask = NB'(8'h01);
      end
      bus.in_size == 2'd1: begin
        amask = 3'd1;
        lmask = NB'(8'h03);
      end
      bus.in_size == 2'd2: begin
        amask = 3'd3;
        lmask = NB'(8'h0f);
      end
      bus.in_size == 2'd3: begin
        amask = 3'd7;
        lmask = '1;
      end
    endcase
  end

  // a double access has no meaning on a 32-bit datapath
  assign err_in = (|(bus.in_addr[2:0] & amask))
               || (bus.in_size == 2'd3 && XLEN == 32);

  assign sh = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_ext = sh;
    unique case (1'b1)
      size_q == 2'd0: begin
        if (uns_q) ld_ext = XLEN'(sh[7:0]);
        else       ld_ext = XLEN'($signed(sh[7:0]));
      end
      size_q == 2'd1: begin
        if (uns_q) ld_ext = XLEN'(sh[15:0]);
        else       ld_ext = XLEN'($signed(sh[15:0]));
      end
      size_q == 2'd2: begin
        if (uns_q) ld_ext = XLEN'(sh[31:0]);
        else       ld_ext = XLEN'($signed(sh[31:0]));
      end
      size_q == 2'd3: ld_ext = sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = err_in ? RESP : REQ;
      REQ:  if (bus.mem_req_ready) state_nx = WAIT;
      WAIT: if (bus.mem_rsp_valid) state_nx = RESP;
      RESP: if (bus.out_ready)     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.in_ready      = (state == IDLE);
  assign bus.mem_req_valid = (state == REQ);
  assign bus.out_valid     = (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'd0;
      off_q         <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      bus.out_rdata <= '0;
      bus.out_rd    <= 5'd0;
      bus.out_wen   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      if (accept) begin
        st_q          <= bus.in_store;
        uns_q         <= bus.in_unsigned;
        size_q        <= bus.in_size;
        off_q         <= off_in;
        bus.mem_we    <= bus.in_store && !err_in;
        bus.mem_addr  <= {bus.in_addr[ADDR_W-1:OW],
                          {OW{1'b0}}};
        bus.mem_wdata <= bus.in_wdata << {off_in, 3'b000};
        bus.mem_wmask <= (bus.in_store && !err_in)
                       ? (lmask << off_in) : '0;
        bus.out_rdata <= '0;
        bus.out_rd    <= bus.in_rd;
        bus.out_wen   <= 1'b0;
        bus.out_err   <= err_in;
      end
      if (state == WAIT && bus.mem_rsp_valid) begin
        bus.out_rdata <= st_q ? '0 : ld_ext;
        bus.out_wen   <= !st_q && (bus.out_rd != 5'd0);
      end
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Directed scoreboard bench for the load/store unit,
// covering the 64-bit build plus a 32-bit size check.
module tb_ysyx_22050612_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050612_lsu_if #(.XLEN(64), .ADDR_W(64)) b64();
  ysyx_22050612_lsu_if #(.XLEN(32), .ADDR_W(32)) b32();

  ysyx_22050612_lsu #(.XLEN(64), .ADDR_W(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  ysyx_22050612_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        wen;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int nreq  = 0;
  int nres  = 0;

  always @(posedge clk) begin
    if (b64.mem_req_valid && b64.mem_req_ready) nreq++;
    if (b64.out_valid && b64.out_ready) nres++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] junk();
    return {$urandom, $urandom};
  endfunction

  task automatic access(
    input logic        st,
    input logic [1:0]  sz,
    input logic        un,
    input logic [63:0] a,
    input logic [63:0] wd,
    input logic [4:0]  rd,
    input logic [63:0] rdat,
    input int          dreq,
    input int          drsp,
    input int          dout,
    input logic        eerr,
    input logic [63:0] emaddr,
    input logic [7:0]  emask,
    input logic [63:0] emwd,
    input logic [63:0] erd,
    input logic        ewen
  );
    exp_t e;
    int r0, o0;
    e = '{rdata: erd, rd: rd, wen: ewen, err: eerr};
    sb.push_back(e);
    r0 = nreq;
    o0 = nres;
    chk("in_ready_idle", b64.in_ready, 1);
    b64.in_valid    = 1'b1;
    b64.in_store    = st;
    b64.in_size     = sz;
    b64.in_unsigned = un;
    b64.in_addr     = a;
    b64.in_wdata    = wd;
    b64.in_rd       = rd;
    tick();
    b64.in_valid    = 1'b0;
    b64.in_store    = ~st;
    b64.in_unsigned = ~un;
    b64.in_addr     = junk();
    b64.in_wdata    = junk();
    b64.in_rd       = 5'($urandom);
    chk("in_ready_busy", b64.in_ready, 0);
    if (!eerr) begin
      for (int i = 0; i <= dreq; i++) begin
        chk("req_valid", b64.mem_req_valid, 1);
        chk("mem_addr", b64.mem_addr, emaddr);
        chk("mem_wmask", 64'(b64.mem_wmask), 64'(emask));
        chk("mem_we", 64'(b64.mem_we), 64'(st));
        if (st) chk("mem_wdata", b64.mem_wdata, emwd);
        chk("out_valid_req", b64.out_valid, 0);
        chk("in_ready_req", b64.in_ready, 0);
        b64.mem_req_ready = (i == dreq);
        b64.mem_rsp_valid = (i < dreq);
        b64.mem_rdata     = junk();
        tick();
      end
      b64.mem_req_ready = 1'b0;
      b64.mem_rsp_valid = 1'b0;
      for (int i = 0; i <= drsp; i++) begin
        chk("req_valid_wait", b64.mem_req_valid, 0);
        chk("out_valid_wait", b64.out_valid, 0);
        b64.mem_rsp_valid = (i == drsp);
        b64.mem_rdata     = (i == drsp) ? rdat : junk();
        tick();
      end
      b64.mem_rsp_valid = 1'b0;
      b64.mem_rdata     = junk();
    end else begin
      chk("req_valid_err", b64.mem_req_valid, 0);
    end
    for (int i = 0; i <= dout; i++) begin
      chk("out_valid", b64.out_valid, 1);
      chk("out_rdata", b64.out_rdata, sb[0].rdata);
      chk("out_rd", 64'(b64.out_rd), 64'(sb[0].rd));
      chk("out_wen", 64'(b64.out_wen), 64'(sb[0].wen));
      chk("out_err", 64'(b64.out_err), 64'(sb[0].err));
      chk("in_ready_resp", b64.in_ready, 0);
      chk("req_valid_resp", b64.mem_req_valid, 0);
      b64.out_ready = (i == dout);
      if (i == dout) void'(sb.pop_front());
      tick();
    end
    b64.out_ready = 1'b0;
    chk("out_valid_done", b64.out_valid, 0);
    chk("in_ready_done", b64.in_ready, 1);
    chk("nreq", 64'(nreq - r0), eerr ? 64'd0 : 64'd1);
    chk("nres", 64'(nres - o0), 64'd1);
  endtask

  initial begin
    b64.in_valid = 0; b64.in_store = 0;
    b64.in_size = 0; b64.in_unsigned = 0;
    b64.in_addr = 0; b64.in_wdata = 0; b64.in_rd = 0;
    b64.mem_req_ready = 0; b64.mem_rsp_valid = 0;
    b64.mem_rdata = 0; b64.out_ready = 0;
    b32.in_valid = 0; b32.in_store = 0;
    b32.in_size = 0; b32.in_unsigned = 0;
    b32.in_addr = 0; b32.in_wdata = 0; b32.in_rd = 0;
    b32.mem_req_ready = 0; b32.mem_rsp_valid = 0;
    b32.mem_rdata = 0; b32.out_ready = 0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", b64.in_ready, 1);
    chk("rst_req_valid", b64.mem_req_valid, 0);
    chk("rst_out_valid", b64.out_valid, 0);
    chk("rst_mem_we", b64.mem_we, 0);
    chk("rst_out_wen", b64.out_wen, 0);
    chk("rst_out_err", b64.out_err, 0);
    chk("rst_wmask", 64'(b64.mem_wmask), 0);
    chk("rst_wdata", b64.mem_wdata, 0);
    chk("rst_addr", b64.mem_addr, 0);
    chk("rst_rdata", b64.out_rdata, 0);
    chk("rst_rd", 64'(b64.out_rd), 0);
    rst = 1'b0;
    tick();

    // store half
    access(1, 2'd1, 0, 64'h8000_0006, 64'h1234, 5'd3,
           64'h0, 0, 0, 0, 0,
           64'h8000_0000, 8'hC0, 64'h1234_0000_0000_0000,
           64'h0, 0);
    // load byte signed / unsigned
    access(0, 2'd0, 0, 64'h8000_0003, 64'h0, 5'd5,
           64'h0000_0000_8000_0000, 0, 0, 0, 0,
           64'h8000_0000, 8'h00, 64'h0,
           64'hFFFF_FFFF_FFFF_FF80, 1);
    access(0, 2'd0, 1, 64'h8000_0003, 64'h0, 5'd5,
           64'h0000_0000_8000_0000, 0, 0, 0, 0,
           64'h8000_0000, 8'h00, 64'h0,
           64'h80, 1);
    // load word signed / unsigned
    access(0, 2'd2, 0, 64'h8000_0004, 64'h0, 5'd6,
           64'h8765_4321_0000_0000, 0, 0, 0, 0,
           64'h8000_0000, 8'h00, 64'h0,
           64'hFFFF_FFFF_8765_4321, 1);
    access(0, 2'd2, 1, 64'h8000_0004, 64'h0, 5'd6,
           64'h8765_4321_0000_0000, 0, 0, 0, 0,
           64'h8000_0000, 8'h00, 64'h0,
           64'h0000_0000_8765_4321, 1);
    // misaligned word
    access(0, 2'd2, 0, 64'h8000_0002, 64'h0, 5'd9,
           64'h0, 0, 0, 0, 1,
           64'h0, 8'h00, 64'h0,
           64'h0, 0);
    // half unsigned to x0
    access(0, 2'd1, 1, 64'h8000_0002, 64'h0, 5'd0,
           64'h0000_0000_ABCD_0000, 0, 1, 0, 0,
           64'h8000_0000, 8'h00, 64'h0,
           64'h0000_0000_0000_ABCD, 0);
    // store byte with light stalls
    access(1, 2'd0, 0, 64'h8000_0005, 64'hA5, 5'd2,
           64'h0, 1, 0, 1, 0,
           64'h8000_0000, 8'h20, 64'h0000_A500_0000_0000,
           64'h0, 0);
    // heavy backpressure, stray responses while in REQ
    access(0, 2'd3, 0, 64'h8000_0008, 64'h0, 5'd12,
           64'h0123_4567_89AB_CDEF, 3, 4, 2, 0,
           64'h8000_0008, 8'h00, 64'h0,
           64'h0123_4567_89AB_CDEF, 1);

    // reset while waiting for memory
    b64.in_valid = 1; b64.in_store = 0;
    b64.in_size = 2'd2; b64.in_unsigned = 0;
    b64.in_addr = 64'h8000_0000; b64.in_rd = 5'd4;
    tick();
    b64.in_valid = 0;
    b64.mem_req_ready = 1;
    tick();
    b64.mem_req_ready = 0;
    chk("abort_req_low", b64.mem_req_valid, 0);
    chk("abort_busy", b64.in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", b64.in_ready, 1);
    chk("abort_req_valid", b64.mem_req_valid, 0);
    chk("abort_out_valid", b64.out_valid, 0);
    chk("abort_addr", b64.mem_addr, 0);
    chk("abort_rd", 64'(b64.out_rd), 0);
    chk("abort_err", b64.out_err, 0);
    b64.mem_rsp_valid = 1;
    b64.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    b64.mem_rsp_valid = 0;
    chk("stale_out_valid", b64.out_valid, 0);
    chk("stale_in_ready", b64.in_ready, 1);
    chk("stale_rdata", b64.out_rdata, 0);
    chk("stale_wen", b64.out_wen, 0);
    tick();
    chk("stale_still_idle", b64.out_valid, 0);
    access(0, 2'd2, 1, 64'h8000_0010, 64'h0, 5'd4,
           64'h0000_0000_CAFE_F00D, 0, 0, 0, 0,
           64'h8000_0010, 8'h00, 64'h0,
           64'h0000_0000_CAFE_F00D, 1);

    // 32-bit build rejects double accesses
    chk("x32_in_ready", b32.in_ready, 1);
    b32.in_valid = 1; b32.in_store = 0;
    b32.in_size = 2'd3; b32.in_addr = 32'h8000_0000;
    b32.in_rd = 5'd7;
    tick();
    b32.in_valid = 0;
    chk("x32_req_valid", b32.mem_req_valid, 0);
    chk("x32_out_valid", b32.out_valid, 1);
    chk("x32_out_err", b32.out_err, 1);
    chk("x32_out_wen", b32.out_wen, 0);
    chk("x32_out_rdata", 64'(b32.out_rdata), 0);
    chk("x32_out_rd", 64'(b32.out_rd), 7);
    b32.out_ready = 1;
    tick();
    b32.out_ready = 0;
    chk("x32_idle", b32.in_ready, 1);
    chk("x32_out_done", b32.out_valid, 0);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
